// File: rtl/text_line_renderer_16x1_pkg.sv
// Shared definitions for the 16x1 text-line renderer: ASCII codes, glyph geometry,
// font address layout and the pipeline's video-timing bundle.
package text_line_renderer_16x1_pkg;

   localparam logic [6:0] CH_BLANK = 7'h20;
   localparam logic [6:0] CH_COLON = 7'h3a;

   localparam int GLYPH_W    = 8;
   localparam int GLYPH_H    = 16;
   localparam int LINE_CHARS = 16;

   localparam int CODE_W  = 7;
   localparam int ROW_W   = 4;
   localparam int COL_W   = 3;
   localparam int CHAR_W  = 4;
   localparam int FONT_AW = CODE_W + ROW_W;

   typedef struct packed {
      logic video_on;
      logic hsync;
      logic vsync;
   } vid_t;

   // Syncs are active-low, so an idle pipeline carries them high.
   localparam vid_t VID_RST = '{video_on: 1'b0, hsync: 1'b1, vsync: 1'b1};

   typedef struct packed {
      logic              in_win;
      logic [CHAR_W-1:0] chr;
      logic [COL_W-1:0]  col;
      logic [ROW_W-1:0]  row;
      vid_t              vid;
   } s1_t;

   // Font rows store the leftmost pixel in the MSB.
   function automatic logic glyph_bit(input logic [GLYPH_W-1:0] row_bits,
                                      input logic [COL_W-1:0]   col);
      return row_bits[~col];
   endfunction

endpackage

// File: rtl/text_line_renderer_16x1_blink_ctrl.sv
// Blink phase generator: counts vsync falling edges and toggles the visible phase
// every BLINK_FRAMES frames.
module text_line_renderer_16x1_blink_ctrl #(
   parameter int BLINK_FRAMES = 32
) (
   input  logic clk,
   input  logic rst_n,
   input  logic vsync,
   output logic blink_phase
);

   localparam logic [7:0] FRAME_TC = 8'(BLINK_FRAMES - 1);

   logic       vsync_q;
   logic [7:0] frame_cnt;
   logic       vsync_fall;

   assign vsync_fall = vsync_q & ~vsync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_q     <= 1'b1;
         frame_cnt   <= 8'd0;
         blink_phase <= 1'b1;
      end else begin
         vsync_q <= vsync;
         if (vsync_fall) begin
            if (frame_cnt == FRAME_TC) begin
               frame_cnt   <= 8'd0;
               blink_phase <= ~blink_phase;
            end else begin
               frame_cnt <= frame_cnt + 8'd1;
            end
         end
      end
   end

endmodule

// File: rtl/text_line_renderer_16x1.sv
// Three-stage text pixel pipeline: pixel coordinate -> char ROM address -> font ROM
// address -> glyph bit, with video timing delayed to stay aligned.
module text_line_renderer_16x1
   import text_line_renderer_16x1_pkg::*;
#(
   parameter logic [9:0] ORIGIN_X     = 10'd0,
   parameter logic [9:0] ORIGIN_Y     = 10'd0,
   parameter int         SCALE_LOG2   = 0,
   parameter bit         BLINK_EN     = 1'b0,
   parameter int         BLINK_FRAMES = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               video_on,
   input  logic               hsync,
   input  logic               vsync,
   input  logic [9:0]         pixel_x,
   input  logic [9:0]         pixel_y,
   output logic [7:0]         char_xy,
   input  logic [CODE_W-1:0]  char_code,
   output logic [FONT_AW-1:0] font_addr,
   input  logic [GLYPH_W-1:0] font_row,
   output logic               text_on,
   output logic               text_pixel,
   output logic               video_on_d,
   output logic               hsync_d,
   output logic               vsync_d
);

   localparam logic [10:0] WIN_W = 11'(LINE_CHARS * GLYPH_W) << SCALE_LOG2;
   localparam logic [10:0] WIN_H = 11'(GLYPH_H) << SCALE_LOG2;

   logic [10:0] dx;
   logic [10:0] dy;
   logic        in_win;
   logic [6:0]  sx;
   logic [3:0]  sy;

   // Extra borrow bit: a pixel left of / above the origin lands at >=1024 and fails
   // the window compare, so the screen edge never wraps into the window.
   assign dx     = {1'b0, pixel_x} - {1'b0, ORIGIN_X};
   assign dy     = {1'b0, pixel_y} - {1'b0, ORIGIN_Y};
   assign in_win = (dx < WIN_W) && (dy < WIN_H);
   assign sx     = 7'(dx[9:0] >> SCALE_LOG2);
   assign sy     = 4'(dy[9:0] >> SCALE_LOG2);

   s1_t               s1;
   logic [FONT_AW-1:0] s2_font_addr;
   logic [COL_W-1:0]   s2_col;
   logic               s2_in_win;
   vid_t               s2_vid;
   logic [COL_W-1:0]   s3_col;
   logic               s3_in_win;
   vid_t               s3_vid;
   logic               blink_phase;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= '{in_win: 1'b0, chr: '0, col: '0, row: '0, vid: VID_RST};
      end else begin
         s1.in_win <= in_win;
         s1.chr    <= sx[6:3];
         s1.col    <= sx[2:0];
         s1.row    <= sy;
         s1.vid    <= '{video_on: video_on, hsync: hsync, vsync: vsync};
      end
   end

   assign char_xy = s1.in_win ? {4'h0, s1.chr} : 8'h00;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_font_addr <= '0;
         s2_col       <= '0;
         s2_in_win    <= 1'b0;
         s2_vid       <= VID_RST;
      end else begin
         s2_font_addr <= s1.in_win ? {char_code, s1.row} : {CH_BLANK, 4'h0};
         s2_col       <= s1.col;
         s2_in_win    <= s1.in_win;
         s2_vid       <= s1.vid;
      end
   end

   assign font_addr = s2_font_addr;

   // font_row arrives from the external ROM in this stage, so the pixel itself is
   // formed combinationally from the stage-3 registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s3_col    <= '0;
         s3_in_win <= 1'b0;
         s3_vid    <= VID_RST;
      end else begin
         s3_col    <= s2_col;
         s3_in_win <= s2_in_win;
         s3_vid    <= s2_vid;
      end
   end

   generate
      if (BLINK_EN) begin : g_blink
         text_line_renderer_16x1_blink_ctrl #(
            .BLINK_FRAMES (BLINK_FRAMES)
         ) u_blink (
            .clk         (clk),
            .rst_n       (rst_n),
            .vsync       (vsync),
            .blink_phase (blink_phase)
         );
      end else begin : g_no_blink
         assign blink_phase = 1'b1;
      end
   endgenerate

   assign text_on    = s3_in_win & s3_vid.video_on;
   assign text_pixel = text_on & glyph_bit(font_row, s3_col) & blink_phase;
   assign video_on_d = s3_vid.video_on;
   assign hsync_d    = s3_vid.hsync;
   assign vsync_d    = s3_vid.vsync;

endmodule

// File: tb/tb_text_line_renderer_16x1.sv
// Directed bench for text_line_renderer_16x1: four parameterisations sharing one
// stimulus bus, each with its own char ROM and sync-read font ROM model.
module tb_text_line_renderer_16x1;

   logic       clk;
   logic       rst_n;
   logic       video_on;
   logic       hsync;
   logic       vsync;
   logic [9:0] pixel_x;
   logic [9:0] pixel_y;

   logic [7:0]  char_xy_a, char_xy_b, char_xy_c, char_xy_d;
   logic [6:0]  char_code_a, char_code_b, char_code_c, char_code_d;
   logic [10:0] font_addr_a, font_addr_b, font_addr_c, font_addr_d;
   logic [7:0]  font_row_a, font_row_b, font_row_c, font_row_d;
   logic text_on_a, text_on_b, text_on_c, text_on_d;
   logic text_pixel_a, text_pixel_b, text_pixel_c, text_pixel_d;
   logic video_on_d_a, video_on_d_b, video_on_d_c, video_on_d_d;
   logic hsync_d_a, hsync_d_b, hsync_d_c, hsync_d_d;
   logic vsync_d_a, vsync_d_b, vsync_d_c, vsync_d_d;

   int n_chk  = 0;
   int n_pass = 0;

   // "RED Player     :" -- colon sits in the last cell
   function automatic logic [6:0] char_rom(input logic [3:0] i);
      case (i)
         4'd0:  return 7'h52;
         4'd1:  return 7'h45;
         4'd2:  return 7'h44;
         4'd4:  return 7'h50;
         4'd5:  return 7'h6c;
         4'd6:  return 7'h61;
         4'd7:  return 7'h79;
         4'd8:  return 7'h65;
         4'd9:  return 7'h72;
         4'd15: return 7'h3a;
         default: return 7'h20;
      endcase
   endfunction

   // Synthetic font: 'R' row 0 = 8'hAA, ':' row 5 = 8'h2F
   function automatic logic [7:0] font_rom(input logic [10:0] a);
      return {a[10:4], 1'b1} ^ {a[3:0], ~a[3:0]};
   endfunction

   assign char_code_a = char_rom(char_xy_a[3:0]);
   assign char_code_b = char_rom(char_xy_b[3:0]);
   assign char_code_c = char_rom(char_xy_c[3:0]);
   assign char_code_d = char_rom(char_xy_d[3:0]);

   always @(posedge clk) begin
      font_row_a <= font_rom(font_addr_a);
      font_row_b <= font_rom(font_addr_b);
      font_row_c <= font_rom(font_addr_c);
      font_row_d <= font_rom(font_addr_d);
   end

   text_line_renderer_16x1 u_dut_a (
      .clk(clk), .rst_n(rst_n), .video_on(video_on), .hsync(hsync), .vsync(vsync),
      .pixel_x(pixel_x), .pixel_y(pixel_y), .char_xy(char_xy_a), .char_code(char_code_a),
      .font_addr(font_addr_a), .font_row(font_row_a), .text_on(text_on_a),
      .text_pixel(text_pixel_a), .video_on_d(video_on_d_a), .hsync_d(hsync_d_a),
      .vsync_d(vsync_d_a));

   text_line_renderer_16x1 #(.ORIGIN_X(10'd100)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .video_on(video_on), .hsync(hsync), .vsync(vsync),
      .pixel_x(pixel_x), .pixel_y(pixel_y), .char_xy(char_xy_b), .char_code(char_code_b),
      .font_addr(font_addr_b), .font_row(font_row_b), .text_on(text_on_b),
      .text_pixel(text_pixel_b), .video_on_d(video_on_d_b), .hsync_d(hsync_d_b),
      .vsync_d(vsync_d_b));

   text_line_renderer_16x1 #(.SCALE_LOG2(1)) u_dut_c (
      .clk(clk), .rst_n(rst_n), .video_on(video_on), .hsync(hsync), .vsync(vsync),
      .pixel_x(pixel_x), .pixel_y(pixel_y), .char_xy(char_xy_c), .char_code(char_code_c),
      .font_addr(font_addr_c), .font_row(font_row_c), .text_on(text_on_c),
      .text_pixel(text_pixel_c), .video_on_d(video_on_d_c), .hsync_d(hsync_d_c),
      .vsync_d(vsync_d_c));

   text_line_renderer_16x1 #(.BLINK_EN(1'b1), .BLINK_FRAMES(2)) u_dut_d (
      .clk(clk), .rst_n(rst_n), .video_on(video_on), .hsync(hsync), .vsync(vsync),
      .pixel_x(pixel_x), .pixel_y(pixel_y), .char_xy(char_xy_d), .char_code(char_code_d),
      .font_addr(font_addr_d), .font_row(font_row_d), .text_on(text_on_d),
      .text_pixel(text_pixel_d), .video_on_d(video_on_d_d), .hsync_d(hsync_d_d),
      .vsync_d(vsync_d_d));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic apply(input logic [9:0] x, input logic [9:0] y,
                        input logic von, input logic hs, input logic vs);
      pixel_x  = x;
      pixel_y  = y;
      video_on = von;
      hsync    = hs;
      vsync    = vs;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      apply(10'd700, 10'd500, 1'b0, 1'b1, 1'b1);
   endtask

   logic [15:0] pat_c;
   logic [3:0]  blink_exp;

   initial begin
      rst_n    = 1'b1;
      pixel_x  = 10'd700;
      pixel_y  = 10'd500;
      video_on = 1'b0;
      hsync    = 1'b1;
      vsync    = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check_eq("rst_text_on", text_on_a, 1'b0);
      check_eq("rst_text_pixel", text_pixel_a, 1'b0);
      check_eq("rst_hsync_d", hsync_d_a, 1'b1);
      check_eq("rst_vsync_d", vsync_d_a, 1'b1);
      check_eq("rst_video_on_d", video_on_d_a, 1'b0);
      check_eq("rst_font_addr", font_addr_a, 11'h000);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      repeat (4) idle();

      // origin (0,0): first cell, last cell, first pixel past the window
      apply(10'd0, 10'd0, 1'b1, 1'b1, 1'b1);
      check_eq("t1_char_xy", char_xy_a, 8'h00);
      apply(10'd127, 10'd5, 1'b1, 1'b1, 1'b1);
      check_eq("t1_font_addr", font_addr_a, 11'h520);
      check_eq("t2_char_xy", char_xy_a, 8'h0F);
      apply(10'd128, 10'd5, 1'b1, 1'b0, 1'b1);
      check_eq("t2_font_addr", font_addr_a, 11'h3A5);
      check_eq("t2_char_xy_out", char_xy_a, 8'h00);
      check_eq("t1_text_on", text_on_a, 1'b1);
      check_eq("t1_text_pixel", text_pixel_a, 1'b1);
      check_eq("t1_hsync_d", hsync_d_a, 1'b1);
      idle();
      check_eq("t2_font_addr_blank", font_addr_a, 11'h200);
      check_eq("t2_text_on", text_on_a, 1'b1);
      check_eq("t2_text_pixel", text_pixel_a, 1'b1);
      idle();
      check_eq("t2_next_text_on", text_on_a, 1'b0);
      check_eq("t2_next_text_pixel", text_pixel_a, 1'b0);
      check_eq("t2_hsync_d", hsync_d_a, 1'b0);
      check_eq("t2_video_on_d", video_on_d_a, 1'b1);
      idle();
      check_eq("t2_video_on_d_off", video_on_d_a, 1'b0);
      repeat (2) idle();

      // origin x=100: left edge and underflow
      apply(10'd99, 10'd0, 1'b1, 1'b1, 1'b1);
      apply(10'd100, 10'd0, 1'b1, 1'b1, 1'b1);
      apply(10'd0, 10'd0, 1'b1, 1'b1, 1'b1);
      check_eq("t3_x99_text_on", text_on_b, 1'b0);
      idle();
      check_eq("t3_x100_text_on", text_on_b, 1'b1);
      check_eq("t3_x100_text_pixel", text_pixel_b, 1'b1);
      idle();
      check_eq("t3_x0_text_on", text_on_b, 1'b0);
      repeat (2) idle();

      // scale 2: each column of 'R' row 0 (8'hAA) drawn twice
      pat_c = 16'hCCCC;
      for (int i = 0; i < 19; i++) begin
         if (i <= 16) apply(10'(i), 10'd0, 1'b1, 1'b1, 1'b1);
         else idle();
         if (i < 16) check_eq("t4_char_xy", char_xy_c, 8'h00);
         else if (i == 16) check_eq("t4_char_xy_next", char_xy_c, 8'h01);
         if (i >= 2 && i < 18) begin
            check_eq("t4_text_on", text_on_c, 1'b1);
            check_eq("t4_text_pixel", text_pixel_c, pat_c[17 - i]);
         end
      end
      repeat (2) idle();

      // blink every 2 frames: phase off after pulse 2, back on after pulse 4
      repeat (3) apply(10'd0, 10'd0, 1'b1, 1'b1, 1'b1);
      check_eq("t5_pre_pixel", text_pixel_d, 1'b1);
      blink_exp = 4'b1001;
      for (int p = 0; p < 4; p++) begin
         repeat (2) apply(10'd0, 10'd0, 1'b1, 1'b1, 1'b0);
         repeat (2) apply(10'd0, 10'd0, 1'b1, 1'b1, 1'b1);
         check_eq("t5_blink_pixel", text_pixel_d, blink_exp[p]);
         if (p == 1) check_eq("t5_blink_text_on", text_on_d, 1'b1);
      end

      // reset pulse in the middle of a visible window
      repeat (4) apply(10'd0, 10'd0, 1'b1, 1'b0, 1'b0);
      check_eq("t6_pre_pixel", text_pixel_a, 1'b1);
      check_eq("t6_pre_hsync_d", hsync_d_a, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check_eq("t6_rst_pixel", text_pixel_a, 1'b0);
      check_eq("t6_rst_text_on", text_on_a, 1'b0);
      check_eq("t6_rst_hsync_d", hsync_d_a, 1'b1);
      check_eq("t6_rst_vsync_d", vsync_d_a, 1'b1);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      apply(10'd0, 10'd0, 1'b1, 1'b0, 1'b0);
      check_eq("t6_rel1_pixel", text_pixel_a, 1'b0);
      apply(10'd0, 10'd0, 1'b1, 1'b0, 1'b0);
      check_eq("t6_rel2_pixel", text_pixel_a, 1'b0);
      apply(10'd0, 10'd0, 1'b1, 1'b0, 1'b0);
      check_eq("t6_rel3_pixel", text_pixel_a, 1'b1);
      check_eq("t6_rel3_text_on", text_on_a, 1'b1);
      check_eq("t6_rel3_hsync_d", hsync_d_a, 1'b0);
      check_eq("t6_rel3_vsync_d", vsync_d_a, 1'b0);
      check_eq("t6_rel3_video_on_d", video_on_d_a, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
